// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB = 0;
  localparam int F3_LSB = 12;
  localparam int F7B    = 30;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch_unit and imem.
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_watchdog.sv
// Response timer for the fetch WAIT state; expire asserts at TIMEOUT_CYCLES-1.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: owns the PC, fetches over the imem channel, holds the instruction
// until the core accepts it. FETCH_ALIGN_CHECK_EN traps misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          XLEN           = XLEN_DEF,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [31:0]     instret,
  output logic            fetch_err
`ifdef FETCH_ALIGN_CHECK_EN
  ,output logic           fetch_misalign
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;
  logic            wd_expire;
  logic            accept;
  logic            redirect_bad;
  logic [XLEN-1:0] redirect_pc;

  assign accept      = (state_q == HOLD) && instr_ready;
  assign redirect_pc = pc_target & {{(XLEN-2){1'b1}}, 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign redirect_bad = pc_src && (pc_target[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q != WAIT),
    .enable (state_q == WAIT),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // A response in the timeout cycle takes priority over the error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      REQ:  if (imem.imem_req_ready) state_d = WAIT;
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_d = HOLD;
        end else if (wd_expire) begin
          state_d = ERR;
        end
      end
      HOLD: if (instr_ready) state_d = redirect_bad ? ERR : REQ;
      ERR:  state_d = ERR;
      default: state_d = REQ;
    endcase
  end

  always_comb begin
    imem.imem_req_valid = (state_q == REQ);
    instr_valid         = (state_q == HOLD);
    fetch_err           = (state_q == ERR);
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    if ((state_q == WAIT) && imem.imem_rsp_valid) begin
      instr_d = imem.imem_rsp_data;
    end
    if (accept) begin
      instret_d = instret_q + 32'd1;
      if (!redirect_bad) begin
        pc_d = pc_src ? redirect_pc : pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= XLEN'(RESET_PC);
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_comb begin
    misalign_d = misalign_q;
    if (accept && redirect_bad) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q;
`endif

  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign op             = instr_q[OP_LSB +: 7];
  assign funct3         = instr_q[F3_LSB +: 3];
  assign funct7         = instr_q[F7B];
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + XLEN'(4);
  assign instret        = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a short watchdog (TIMEOUT_CYCLES=4).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] instret;
  logic        fetch_err;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instret = 0;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN           (32),
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus.master),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .instret     (instret),
    .fetch_err   (fetch_err)
`ifdef FETCH_ALIGN_CHECK_EN
    ,.fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  // Called in REQ at a falling edge; leaves the DUT in HOLD.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
    chk("req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("req_addr", bus.imem_addr, exp_addr);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    chk("wait_req_low", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr", instr, data);
    chk("pc", pc, exp_addr);
  endtask

  task automatic accept(input logic src, input logic [31:0] target);
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = target;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 1'b1;
    pc_target   = 32'h0000_0F00;
    exp_instret = exp_instret + 1;
    chk("instret", instret, exp_instret);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n              = 1'b0;
    instr_ready        = 1'b0;
    pc_src             = 1'b0;
    pc_target          = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instret", instret, 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);

    // First fetch and field decode
    fetch(32'h0, 32'h0050_0093);
    chk("op", 32'(op), 32'h13);
    chk("funct3", 32'(funct3), 32'd0);
    chk("funct7", 32'(funct7), 32'd0);
    chk("pc_plus4", pc_plus4, 32'd4);
    accept(1'b0, 32'h0000_0100);

    fetch(32'h4, 32'h0010_0113);
    accept(1'b0, 32'h0000_0200);
    fetch(32'h8, 32'h0020_0193);
    accept(1'b1, 32'h0000_0040);
    chk("instret_3", instret, 32'd3);
    chk("redirect_addr", bus.imem_addr, 32'h40);

    fetch(32'h40, 32'h0000_0013);
    accept(1'b1, 32'h0000_0042);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_err", 32'(fetch_err), 32'd1);
    chk("misalign_flag", 32'(fetch_misalign), 32'd1);
    chk("misalign_pc", pc, 32'h40);
    do_reset();
    chk("misalign_cleared", 32'(fetch_misalign), 32'd0);
    fetch(32'h0, 32'h0000_0013);
    accept(1'b1, 32'h0000_0040);
`else
    chk("forced_align_addr", bus.imem_addr, 32'h40);
`endif

    // Request backpressure with a stray response pulse that must be ignored
    for (int i = 0; i < 5; i++) begin
      bus.imem_rsp_valid = (i == 2);
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("stall_addr", bus.imem_addr, 32'h40);
      chk("stall_no_instr", 32'(instr_valid), 32'd0);
    end

    fetch(32'h40, 32'h4000_5033);
    chk("op_r", 32'(op), 32'h33);
    chk("funct3_r", 32'(funct3), 32'd5);
    chk("funct7_r", 32'(funct7), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_instr", instr, 32'h4000_5033);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instret", instret, exp_instret);
      chk("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    accept(1'b0, 32'h0000_0000);
    chk("seq_addr", bus.imem_addr, 32'h44);

    // Timeout: error exactly 4 cycles after the handshake
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_no_err", 32'(fetch_err), 32'd0);
    end
    @(negedge clk);
    chk("timeout_err", 32'(fetch_err), 32'd1);
    chk("err_req_low", 32'(bus.imem_req_valid), 32'd0);
    chk("err_instr_low", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("err_sticky", 32'(fetch_err), 32'd1);
    chk("err_instret", instret, exp_instret);

    do_reset();
    chk("rst2_err", 32'(fetch_err), 32'd0);
    chk("rst2_addr", bus.imem_addr, 32'h0);

    // Response in the final watchdog cycle wins over the timeout
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0000_0033;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk("late_rsp_no_err", 32'(fetch_err), 32'd0);
    chk("late_rsp_valid", 32'(instr_valid), 32'd1);
    chk("late_rsp_instr", instr, 32'h0000_0033);

    // PC wrap at the top of the address space
    accept(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0013);
    chk("wrap_plus4", pc_plus4, 32'h0);
    accept(1'b0, 32'h0000_0000);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_no_err", 32'(fetch_err), 32'd0);

    // Reset while a request is outstanding
    fetch(32'h0, 32'h1234_5013);
    accept(1'b0, 32'h0);
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    do_reset();
    chk("midwait_addr", bus.imem_addr, 32'h0);
    chk("midwait_req", 32'(bus.imem_req_valid), 32'd1);
    chk("midwait_instret", instret, 32'd0);
    chk("midwait_instr", instr, 32'h0000_0013);
    chk("midwait_err", 32'(fetch_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control unit and datapath in the single-cycle RV32 core. It owns the PC register and issues requests to instruction memory over a valid/ready request channel and a valid response channel. It holds the fetched instruction, exposing the op/funct3/funct7 fields the control unit decodes, until the core accepts it. On acceptance it applies the core's PCSrc/PCTarget redirect.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset
TIMEOUT_CYCLES, 64, max cycles in WAIT before fetch error (range 2..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  request address, word aligned
imem_rsp_valid  in  1  response data valid, single-cycle pulse
imem_rsp_data  in  32  instruction word
instr_valid  out  1  held instruction valid
instr_ready  in  1  core consumes held instruction this cycle
instr  out  32  held instruction
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  1  instr[30]
pc  out  XLEN  address of held instruction
pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN
pc_src  in  1  redirect select from control unit (PCSrc)
pc_target  in  XLEN  branch/jump target
instret  out  32  retired-instruction counter
fetch_err  out  1  sticky fetch error

Behaviour:
- Reset: clk and rst_n as named above; reset is synchronous, active-low, sampled on the clk rising edge. While rst_n=0 at an edge: state<=REQ, pc<=RESET_PC, instr<=32'h0000_0013 (NOP), instret<=0, timer<=0, fetch_err<=0. Outputs are registered or decoded from state, so the first cycle after reset drives imem_req_valid=1 and imem_addr=RESET_PC.
- FSM states: REQ, WAIT, HOLD, ERR.
- REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready=1 -> WAIT with timer<=0. imem_addr stays stable while stalled.
- WAIT: imem_req_valid=0, timer increments each cycle. If imem_rsp_valid=1 -> instr<=imem_rsp_data and go to HOLD; response-to-instr_valid latency is 1 cycle. If there is no response and timer==TIMEOUT_CYCLES-1 -> ERR. A response arriving in the same cycle as the timeout wins.
- HOLD: instr_valid=1. instr, pc and the decoded fields are stable until accepted. On instr_ready=1: pc<=pc_src ? {pc_target[XLEN-1:2],2'b00} : pc+4, instret<=instret+1 (wraps at 2^32), then -> REQ. The next request is asserted in the cycle after acceptance. pc_src and pc_target are sampled only in the accept cycle.
- ERR: fetch_err=1, imem_req_valid=0, instr_valid=0. ERR is left only by reset.
- imem_rsp_valid in REQ/HOLD/ERR is a protocol violation and is ignored; no state change.
- instr_valid=1 only in HOLD. instr_ready outside HOLD is ignored.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no error.
- Reset mid-WAIT abandons the outstanding request. Instruction memory must drop in-flight responses on reset.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: an accepted redirect with pc_src=1 and pc_target[1:0]!=0 -> ERR, pc unchanged, instret still increments. An extra output fetch_misalign (1 bit) is set sticky alongside fetch_err.
- Undefined: pc_target[1:0] is silently forced to 00 and the fetch_misalign port does not exist.

Decomposition:
- Package fetch_pkg holds: the state enum (REQ, WAIT, HOLD, ERR), XLEN default, NOP_INSTR=32'h0000_0013, opcode field bit positions (OP_LSB=0, F3_LSB=12, F7B=30).
- One natural sub-module, fetch_watchdog: the timer with clear/enable inputs and an expire output at TIMEOUT_CYCLES-1.
- Everything else lives in fetch_unit.

Test Plan:
- Reset then imem_req_ready=1 with a 1-cycle response 32'h00500093 -> imem_addr=0, instr_valid 2 cycles after the request; op=7'h13, funct3=0, funct7=0; pc_plus4=4.
- Sequential: accept 3 instructions with pc_src=0 -> addresses 0,4,8 requested; instret=3.
- Redirect: in HOLD at pc=8, instr_ready=1, pc_src=1, pc_target=32'h40 -> next imem_addr=32'h40. With pc_target=32'h42 and FETCH_ALIGN_CHECK_EN undefined -> addr 32'h40; with it defined -> fetch_err=1, fetch_misalign=1.
- Backpressure: hold imem_req_ready=0 for 5 cycles, then hold instr_ready=0 for 4 cycles -> imem_addr and instr stay stable, instret unchanged.
- Timeout: TIMEOUT_CYCLES=4, no response -> fetch_err=1 exactly 4 cycles after the request handshake. A response on cycle 4 is accepted instead.
- Reset mid-WAIT: rst_n=0 for one edge -> next cycle imem_addr=RESET_PC, instret=0, instr=32'h00000013, fetch_err=0.
